// File: rtl/key_seq_tx.sv
// Transmit side of the 4-bit key-sequence link: streams the six-nibble key on a
// valid/ready bus, optionally repeated and with idle gaps between symbols.
module key_seq_tx #(
  parameter logic [3:0] SYM0     = 4'h1,
  parameter logic [3:0] SYM1     = 4'h3,
  parameter logic [3:0] SYM2     = 4'h4,
  parameter logic [3:0] SYM3     = 4'h8,
  parameter logic [3:0] SYM4     = 4'hD,
  parameter logic [3:0] SYM5     = 4'h9,
  parameter int unsigned GAP     = 0,
  parameter logic [3:0] IDLE_NIB = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] rpt,
  input  logic       abort,
  output logic [3:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy,
  output logic       done,
  output logic [2:0] sym_idx
);

  localparam bit         HasGap  = (GAP != 0);
  localparam logic [3:0] GapLast = HasGap ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StSend, StGap, StFin} state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic [3:0] dout_q, dout_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] sidx_q, sidx_d;
  logic       xfer;
  logic       adv;

  function automatic logic [3:0] sym_of(input logic [2:0] i);
    case (i)
      3'd0:    sym_of = SYM0;
      3'd1:    sym_of = SYM1;
      3'd2:    sym_of = SYM2;
      3'd3:    sym_of = SYM3;
      3'd4:    sym_of = SYM4;
      default: sym_of = SYM5;
    endcase
  endfunction

  assign xfer = valid_q && dout_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rcnt_d  = rcnt_q;
    gcnt_d  = gcnt_q;
    adv     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          rcnt_d  = (rpt == 4'd0) ? 4'd1 : rpt;
          idx_d   = 3'd0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (abort) begin
          state_d = StIdle;
          idx_d   = 3'd0;
          rcnt_d  = 4'd0;
        end else if (xfer) begin
          if (idx_q != 3'd5) begin
            idx_d = idx_q + 3'd1;
            adv   = 1'b1;
          end else if (rcnt_q > 4'd1) begin
            rcnt_d = rcnt_q - 4'd1;
            idx_d  = 3'd0;
            adv    = 1'b1;
          end else begin
            state_d = StFin;
            idx_d   = 3'd0;
            rcnt_d  = 4'd0;
          end
        end
      end
      StGap: begin
        if (abort) begin
          state_d = StIdle;
          idx_d   = 3'd0;
          rcnt_d  = 4'd0;
          gcnt_d  = 4'd0;
        end else if (gcnt_q == GapLast) begin
          state_d = StSend;
          gcnt_d  = 4'd0;
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (adv) begin
      state_d = HasGap ? StGap : StSend;
      gcnt_d  = 4'd0;
    end
  end

  // Outputs are decoded from the next state so they appear registered.
  always_comb begin
    valid_d = (state_d == StSend);
    dout_d  = valid_d ? sym_of(idx_d) : IDLE_NIB;
    busy_d  = (state_d == StSend) || (state_d == StGap);
    done_d  = (state_d == StFin);
    sidx_d  = busy_d ? idx_d : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      rcnt_q  <= 4'd0;
      gcnt_q  <= 4'd0;
      dout_q  <= IDLE_NIB;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sidx_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rcnt_q  <= rcnt_d;
      gcnt_q  <= gcnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sidx_q  <= sidx_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sym_idx    = sidx_q;

endmodule

// File: tb/tb_key_seq_tx.sv
// Scoreboard bench for key_seq_tx: one instance with GAP=0, one with GAP=2.
module tb_key_seq_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, rdy = 1'b1;
  logic [3:0] rpt = 4'd0;
  logic [3:0] dout;
  logic       dv, busy, done;
  logic [2:0] sidx;

  logic       start2 = 1'b0, abort2 = 1'b0, rdy2 = 1'b1;
  logic [3:0] rpt2 = 4'd0;
  logic [3:0] dout2;
  logic       dv2, busy2, done2;
  logic [2:0] sidx2;

  logic [3:0] key [6] = '{4'h1, 4'h3, 4'h4, 4'h8, 4'hD, 4'h9};
  logic [6:0] q0[$];
  logic [6:0] q2[$];
  int n_cmp = 0, n_err = 0;
  int n_xfer0 = 0, done0 = 0, n_xfer2 = 0;

  always #5 clk = ~clk;

  key_seq_tx #(.GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .rpt(rpt), .abort(abort),
    .dout(dout), .dout_valid(dv), .dout_ready(rdy), .busy(busy), .done(done),
    .sym_idx(sidx)
  );

  key_seq_tx #(.GAP(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .rpt(rpt2), .abort(abort2),
    .dout(dout2), .dout_valid(dv2), .dout_ready(rdy2), .busy(busy2), .done(done2),
    .sym_idx(sidx2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push0(input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < 6; i++) q0.push_back({3'(i), key[i]});
  endtask

  task automatic cyc(input logic s, input logic [3:0] r, input logic a, input logic rd);
    @(posedge clk); #1;
    start = s; rpt = r; abort = a; rdy = rd;
    @(negedge clk);
  endtask

  task automatic cyc2(input logic s, input logic [3:0] r);
    @(posedge clk); #1;
    start2 = s; rpt2 = r; abort2 = 1'b0; rdy2 = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done0(input int budget, input string name);
    int k = 0;
    while (!done && k < budget) begin
      cyc(1'b0, 4'd0, 1'b0, 1'b1);
      k++;
    end
    if (!done) chk({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  // Monitors: pop and compare on every transfer.
  always @(negedge clk) begin
    if (dv && rdy) begin
      n_xfer0++;
      if (q0.size() == 0) chk("sb0_unexpected", {25'd0, sidx, dout}, 32'hFFFF);
      else chk("sb0", {25'd0, sidx, dout}, {25'd0, q0.pop_front()});
    end
    if (done) done0++;
  end

  always @(negedge clk) begin
    if (dv2 && rdy2) begin
      n_xfer2++;
      if (q2.size() == 0) chk("sb2_unexpected", {25'd0, sidx2, dout2}, 32'hFFFF);
      else chk("sb2", {25'd0, sidx2, dout2}, {25'd0, q2.pop_front()});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, d0;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dv), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_sidx", 32'(sidx), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: plain sequence, latency and done timing
    push0(1);
    d0 = done0;
    cyc(1'b1, 4'd1, 1'b0, 1'b1);
    chk("t1_idle_valid", 32'(dv), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 4'd0, 1'b0, 1'b1);
      chk($sformatf("t1_dout%0d", i), 32'(dout), 32'(key[i]));
      chk($sformatf("t1_valid%0d", i), 32'(dv), 32'd1);
      chk($sformatf("t1_busy%0d", i), 32'(busy), 32'd1);
    end
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_busy_fin", 32'(busy), 32'd0);
    chk("t1_valid_fin", 32'(dv), 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_done_count", 32'(done0 - d0), 32'd1);

    // 2: backpressure on SYM2
    push0(1);
    cyc(1'b1, 4'd1, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'd0, 1'b0, (i == 2));
      chk($sformatf("t2_hold_dout%0d", i), 32'(dout), 32'h4);
      chk($sformatf("t2_hold_valid%0d", i), 32'(dv), 32'd1);
      chk($sformatf("t2_hold_sidx%0d", i), 32'(sidx), 32'd2);
    end
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t2_resume", 32'(dout), 32'h8);
    wait_done0(10, "t2");
    cyc(1'b0, 4'd0, 1'b0, 1'b1);

    // 3: rpt=0 acts as 1, rpt=3 gives three passes and one done
    x0 = n_xfer0; d0 = done0;
    push0(1);
    cyc(1'b1, 4'd0, 1'b0, 1'b1);
    wait_done0(20, "t3a");
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t3_rpt0_xfers", 32'(n_xfer0 - x0), 32'd6);
    chk("t3_rpt0_done", 32'(done0 - d0), 32'd1);
    x0 = n_xfer0; d0 = done0;
    push0(3);
    cyc(1'b1, 4'd3, 1'b0, 1'b1);
    wait_done0(40, "t3b");
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t3_rpt3_xfers", 32'(n_xfer0 - x0), 32'd18);
    chk("t3_rpt3_done", 32'(done0 - d0), 32'd1);

    // 4: GAP=2 instance
    for (int i = 0; i < 6; i++) q2.push_back({3'(i), key[i]});
    cyc2(1'b1, 4'd1);
    for (int c = 1; c <= 16; c++) begin
      cyc2(1'b0, 4'd0);
      chk($sformatf("t4_valid_c%0d", c), 32'(dv2), 32'(((c - 1) % 3) == 0));
      chk($sformatf("t4_busy_c%0d", c), 32'(busy2), 32'd1);
      if (((c - 1) % 3) != 0) chk($sformatf("t4_gapdout_c%0d", c), 32'(dout2), 32'h0);
      if (c == 2) chk("t4_gap_sidx", 32'(sidx2), 32'd1);
    end
    cyc2(1'b0, 4'd0);
    chk("t4_done", 32'(done2), 32'd1);
    chk("t4_xfers", 32'(n_xfer2), 32'd6);

    // 5: abort at sym_idx 3, abort ignored in idle, restart
    d0 = done0;
    for (int i = 0; i < 4; i++) q0.push_back({3'(i), key[i]});
    cyc(1'b1, 4'd2, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 4'd0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b1, 1'b1);
    chk("t5_sidx_at_abort", 32'(sidx), 32'd3);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t5_valid", 32'(dv), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_sidx", 32'(sidx), 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t5_no_done", 32'(done0 - d0), 32'd0);
    cyc(1'b1, 4'd1, 1'b1, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t5_abort_start_idle", 32'(busy), 32'd0);
    push0(1);
    cyc(1'b1, 4'd1, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t5_restart_dout", 32'(dout), 32'h1);
    chk("t5_restart_sidx", 32'(sidx), 32'd0);
    wait_done0(10, "t5");
    cyc(1'b0, 4'd0, 1'b0, 1'b1);

    // 6: start while busy is ignored, then reset mid-sequence
    x0 = n_xfer0;
    push0(2);
    cyc(1'b1, 4'd2, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    cyc(1'b1, 4'd7, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t6_busy_start_dout", 32'(dout), 32'h4);
    wait_done0(30, "t6");
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t6_xfers", 32'(n_xfer0 - x0), 32'd12);
    for (int i = 0; i < 2; i++) q0.push_back({3'(i), key[i]});
    cyc(1'b1, 4'd1, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("t6_pre_rst_sidx", 32'(sidx), 32'd2);
    rst = 1'b1;
    cyc(1'b0, 4'd0, 1'b0, 1'b0);
    chk("t6_rst_dout", 32'(dout), 32'h0);
    chk("t6_rst_valid", 32'(dv), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_sidx", 32'(sidx), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(1'b0, 4'd0, 1'b0, 1'b1);
    chk("t6_post_rst_idle", 32'(busy), 32'd0);

    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q2_empty", 32'(q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
